// File: rtl/lsu_pkg.sv
// Package for the load/store unit data-memory port.
// Holds the RV64I funct3 width codes, the port FSM state type, and the
// helpers that translate funct3 into an access size and a signedness flag.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // DECODE is the cycle in which the registered request is checked.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // LBU/LHU/LWU zero-extend; everything else sign-extends.
    function automatic logic is_unsigned(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment (combinational).
// Shifts the addressed lane of a 64-bit memory word down to bit 0, truncates
// it to the access size and sign- or zero-extends it to XLEN.
// Ports:
//   word_i    read word from memory
//   offset_i  byte offset within the word (addr[2:0])
//   funct3_i  load width/sign code
//   result_o  extended load result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] shifted;
    logic            uns;

    assign shifted = word_i >> {offset_i, 3'b000};
    assign uns     = is_unsigned(funct3_i);

    always_comb begin
        result_o = shifted;
        case (size_bytes(funct3_i))
            4'd1: result_o = {{(XLEN-8){shifted[7] & ~uns}}, shifted[7:0]};
            4'd2: result_o = {{(XLEN-16){shifted[15] & ~uns}}, shifted[15:0]};
            4'd4: result_o = {{(XLEN-32){shifted[31] & ~uns}}, shifted[31:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// RV64I load/store unit front-end towards the data memory.
// Takes one request at a time, checks funct3 legality and alignment, drives
// the word address / byte strobes / lane-shifted store data, and returns the
// extended load data (or an error) on a response channel.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. resp_valid and the response data stay stable until resp_ready;
// mem_en and all mem_* outputs stay stable until mem_ready.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                        request payload
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             response payload (rdata 0 for stores/errors)
//   mem_en/mem_ready                 memory request handshake
//   mem_we, mem_addr, mem_wstrb,
//   mem_wdata                        memory request payload
//   mem_rdata                        read word, one cycle after an accepted read
//   dbg_state_o                      current FSM state
//
// Build option: define LSU_BOUNDS_CHECK_EN to reject addresses above the
// memory; otherwise the upper address bits are ignored and accesses wrap.
module lsu_dmem_port
    import lsu_pkg::*;
#(
    parameter  int XLEN       = 64,
    parameter  int DMEM_DEPTH = 1024,
    localparam int AW         = $clog2(DMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output lsu_state_e      dbg_state_o
);

    lsu_state_e      state_q, state_d;
    logic [AW+2:0]   addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            oob_q, oob_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [XLEN-1:0] load_data;
    logic            illegal;
    logic            misaligned;
    logic [7:0]      size_mask;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob_d = req_valid ? (|req_addr[XLEN-1:AW+3]) : oob_q;
`else
    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[XLEN-1:AW+3];
    assign oob_d          = 1'b0;
`endif

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .word_i   (mem_rdata),
        .offset_i (addr_q[2:0]),
        .funct3_i (funct3_q),
        .result_o (load_data)
    );

    // Stores only define widths up to SD; loads only lack a 64-bit unsigned form.
    assign illegal    = we_q ? funct3_q[2] : (funct3_q == 3'b111);
    assign misaligned = |(addr_q[2:0] & 3'(size_bytes(funct3_q) - 4'd1));

    always_comb begin
        size_mask = 8'hFF;
        case (size_bytes(funct3_q))
            4'd1:    size_mask = 8'h01;
            4'd2:    size_mask = 8'h03;
            4'd4:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            oob_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            oob_q    <= (state_q == ST_IDLE) ? oob_d : oob_q;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr[AW+2:0];
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    err_d    = 1'b0;
                    rdata_d  = '0;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (illegal || misaligned || oob_q) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_addr = addr_q[AW+2:3];
                if (we_q) begin
                    mem_wstrb = size_mask << addr_q[2:0];
                    mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
                end
                if (mem_ready) begin
                    state_d = we_q ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata  = (state_q == ST_RESP) ? rdata_q : '0;
    assign resp_err    = (state_q == ST_RESP) & err_q;
    assign dbg_state_o = state_q;

endmodule
